// File: rtl/hazard_ctrl.sv
// Stall/forward controller for the 5-stage MIPS pipeline: decodes the stage
// instructions, resolves data and multiply/divide hazards, and picks bypass sources.
module hazard_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IFID_instr,
    input  logic [31:0] IDEX_instr,
    input  logic [31:0] EXMEM_instr,
    input  logic [4:0]  IFID_rs,
    input  logic [4:0]  IFID_rt,
    input  logic [4:0]  IDEX_rs,
    input  logic [4:0]  IDEX_rt,
    input  logic [4:0]  EXMEM_rt,
    input  logic [4:0]  IDEX_WA,
    input  logic [4:0]  EXMEM_WA,
    input  logic [4:0]  MEMWB_WA,
    output logic        PC_en,
    output logic        IFID_en,
    output logic        IDEX_clr,
    output logic [2:0]  FwdRS_D,
    output logic [2:0]  FwdRT_D,
    output logic [1:0]  FwdRS_E,
    output logic [1:0]  FwdRT_E,
    output logic        FwdRT_M,
    output logic        md_start,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [3:0] MULT_LD   = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD    = 4'(DIV_CYC);

    typedef struct packed {
        logic cal_r;
        logic cal_i;
        logic ld;
        logic st;
        logic br;
        logic jr;
        logic jal;
        logic md;
        logic mult;
        logic mf;
        logic mt;
    } cls_t;

    // The all-zero word is a nop even though its opcode/funct match sll.
    function automatic cls_t decode(input logic [31:0] instr);
        cls_t       c;
        logic [5:0] op;
        logic [5:0] fn;
        c  = '0;
        op = instr[31:26];
        fn = instr[5:0];
        if (instr != 32'd0) begin
            case (op)
                OP_SPECIAL: begin
                    case (fn)
                        FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLL: c.cal_r = 1'b1;
                        FN_JR:              c.jr = 1'b1;
                        FN_MULT, FN_MULTU: begin
                            c.md   = 1'b1;
                            c.mult = 1'b1;
                        end
                        FN_DIV, FN_DIVU:    c.md = 1'b1;
                        FN_MFHI, FN_MFLO:   c.mf = 1'b1;
                        FN_MTHI, FN_MTLO:   c.mt = 1'b1;
                        default: ;
                    endcase
                end
                OP_ORI, OP_LUI, OP_ADDIU: c.cal_i = 1'b1;
                OP_LW:                    c.ld    = 1'b1;
                OP_SW:                    c.st    = 1'b1;
                OP_BEQ, OP_BNE:           c.br    = 1'b1;
                OP_JAL:                   c.jal   = 1'b1;
                default: ;
            endcase
        end
        return c;
    endfunction

    // Returns {tuse_rs, tuse_rt}; TUSE_NONE exceeds every Tnew so it never stalls.
    function automatic logic [3:0] tuse(input cls_t c);
        logic [1:0] rs_t;
        logic [1:0] rt_t;
        rs_t = TUSE_NONE;
        rt_t = TUSE_NONE;
        if (c.cal_i || c.ld || c.mt) rs_t = 2'd1;
        if (c.cal_r || c.md) begin
            rs_t = 2'd1;
            rt_t = 2'd1;
        end
        if (c.st) begin
            rs_t = 2'd1;
            rt_t = 2'd2;
        end
        if (c.br) begin
            rs_t = 2'd0;
            rt_t = 2'd0;
        end
        if (c.jr) rs_t = 2'd0;
        return {rs_t, rt_t};
    endfunction

    function automatic logic [1:0] tnew_e(input cls_t c);
        logic [1:0] t;
        t = 2'd0;
        if (c.cal_r || c.cal_i || c.mf) t = 2'd1;
        if (c.ld) t = 2'd2;
        return t;
    endfunction

    function automatic logic [2:0] fwd_d(
        input logic [4:0] r,
        input logic [4:0] idex_wa,
        input logic       idex_jal,
        input logic [4:0] exmem_wa,
        input logic       exmem_ready,
        input logic       exmem_jal,
        input logic [4:0] memwb_wa
    );
        logic [2:0] sel;
        sel = 3'd0;
        if (r != 5'd0) begin
            if (idex_wa == r && idex_jal)            sel = 3'd4;
            else if (exmem_wa == r && exmem_ready)   sel = exmem_jal ? 3'd3 : 3'd2;
            else if (memwb_wa == r)                  sel = 3'd1;
        end
        return sel;
    endfunction

    function automatic logic [1:0] fwd_e(
        input logic [4:0] r,
        input logic [4:0] exmem_wa,
        input logic       exmem_ready,
        input logic       exmem_jal,
        input logic [4:0] memwb_wa
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (r != 5'd0) begin
            if (exmem_wa == r && exmem_ready)  sel = exmem_jal ? 2'd3 : 2'd2;
            else if (memwb_wa == r)            sel = 2'd1;
        end
        return sel;
    endfunction

    cls_t       ifid_cls;
    cls_t       idex_cls;
    cls_t       exmem_cls;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [1:0] tnew_idex;
    logic [1:0] tnew_exmem;
    logic       exmem_ready;
    logic       haz_e;
    logic       haz_m;
    logic       haz_md;
    logic       stall;

    logic [3:0]  md_cnt_q, md_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign ifid_cls  = decode(IFID_instr);
    assign idex_cls  = decode(IDEX_instr);
    assign exmem_cls = decode(EXMEM_instr);

    // Not every stage needs every class bit; fold the rest into one sink.
    logic unused_cls;
    assign unused_cls = ^{ifid_cls, idex_cls, exmem_cls};

    always_comb begin
        {tuse_rs, tuse_rt} = tuse(ifid_cls);
        tnew_idex   = tnew_e(idex_cls);
        tnew_exmem  = exmem_cls.ld ? 2'd1 : 2'd0;
        exmem_ready = (tnew_exmem == 2'd0);

        haz_e = ((IFID_rs != 5'd0) && (IDEX_WA == IFID_rs) && (tnew_idex > tuse_rs)) ||
                ((IFID_rt != 5'd0) && (IDEX_WA == IFID_rt) && (tnew_idex > tuse_rt));
        haz_m = ((IFID_rs != 5'd0) && (EXMEM_WA == IFID_rs) && (tnew_exmem > tuse_rs)) ||
                ((IFID_rt != 5'd0) && (EXMEM_WA == IFID_rt) && (tnew_exmem > tuse_rt));
        haz_md = (ifid_cls.md || ifid_cls.mf || ifid_cls.mt) && (md_start || md_busy);
        stall  = haz_e || haz_m || haz_md;
    end

    assign PC_en    = ~stall;
    assign IFID_en  = ~stall;
    assign IDEX_clr = stall;

    assign FwdRS_D = fwd_d(IFID_rs, IDEX_WA, idex_cls.jal, EXMEM_WA, exmem_ready,
                           exmem_cls.jal, MEMWB_WA);
    assign FwdRT_D = fwd_d(IFID_rt, IDEX_WA, idex_cls.jal, EXMEM_WA, exmem_ready,
                           exmem_cls.jal, MEMWB_WA);
    assign FwdRS_E = fwd_e(IDEX_rs, EXMEM_WA, exmem_ready, exmem_cls.jal, MEMWB_WA);
    assign FwdRT_E = fwd_e(IDEX_rt, EXMEM_WA, exmem_ready, exmem_cls.jal, MEMWB_WA);
    assign FwdRT_M = (EXMEM_rt != 5'd0) && (MEMWB_WA == EXMEM_rt);

    assign md_start  = idex_cls.md;
    assign md_busy   = (md_cnt_q != 4'd0);
    assign stall_cnt = stall_cnt_q;

    // A new MD op in E always reloads, even over a running count or a D-stage stall.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start)
            md_cnt_d = idex_cls.mult ? MULT_LD : DIV_LD;
        else if (md_cnt_q != 4'd0)
            md_cnt_d = md_cnt_q - 4'd1;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_q    <= 4'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a tiny stage-register model feeds the controller
// and each scenario is compared against hand-derived stall counts and selects.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] IFID_instr, IDEX_instr, EXMEM_instr;
    logic [4:0]  IFID_rs, IFID_rt, IDEX_rs, IDEX_rt, EXMEM_rt;
    logic [4:0]  IDEX_WA, EXMEM_WA, MEMWB_WA;
    logic        PC_en, IFID_en, IDEX_clr;
    logic [2:0]  FwdRS_D, FwdRT_D;
    logic [1:0]  FwdRS_E, FwdRT_E;
    logic        FwdRT_M, md_start, md_busy;
    logic [31:0] stall_cnt;

    hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset),
        .IFID_instr(IFID_instr), .IDEX_instr(IDEX_instr), .EXMEM_instr(EXMEM_instr),
        .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IDEX_rs(IDEX_rs), .IDEX_rt(IDEX_rt),
        .EXMEM_rt(EXMEM_rt), .IDEX_WA(IDEX_WA), .EXMEM_WA(EXMEM_WA), .MEMWB_WA(MEMWB_WA),
        .PC_en(PC_en), .IFID_en(IFID_en), .IDEX_clr(IDEX_clr),
        .FwdRS_D(FwdRS_D), .FwdRT_D(FwdRT_D), .FwdRS_E(FwdRS_E), .FwdRT_E(FwdRT_E),
        .FwdRT_M(FwdRT_M), .md_start(md_start), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wa;
    } ins_t;

    localparam ins_t NOP = '0;

    ins_t       d_s, e_s, m_s;
    logic [4:0] w_wa;
    ins_t       prog[$];
    int         checks;
    int         errors;
    int         n;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic ins_t mk(input logic [31:0] instr, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] wa);
        ins_t x;
        x.instr = instr;
        x.rs    = rs;
        x.rt    = rt;
        x.wa    = wa;
        return x;
    endfunction

    task automatic apply();
        IFID_instr  = d_s.instr;
        IFID_rs     = d_s.rs;
        IFID_rt     = d_s.rt;
        IDEX_instr  = e_s.instr;
        IDEX_rs     = e_s.rs;
        IDEX_rt     = e_s.rt;
        IDEX_WA     = e_s.wa;
        EXMEM_instr = m_s.instr;
        EXMEM_rt    = m_s.rt;
        EXMEM_WA    = m_s.wa;
        MEMWB_WA    = w_wa;
    endtask

    // One pipeline clock: a stall holds D and inserts a bubble into E.
    task automatic step();
        logic st;
        st = IDEX_clr;
        @(posedge clk);
        #1;
        w_wa = m_s.wa;
        m_s  = e_s;
        if (st) begin
            e_s = NOP;
        end else begin
            e_s = d_s;
            d_s = (prog.size() > 0) ? prog.pop_front() : NOP;
        end
        apply();
        #2;
    endtask

    task automatic clear_pipe();
        d_s  = NOP;
        e_s  = NOP;
        m_s  = NOP;
        w_wa = 5'd0;
        prog.delete();
        apply();
        #2;
    endtask

    task automatic count_stalls(input int bound, output int cnt);
        cnt = 0;
        while (IDEX_clr === 1'b1 && cnt < bound) begin
            check_eq("stall_pc_en", 32'(PC_en), 0);
            check_eq("stall_ifid_en", 32'(IFID_en), 0);
            cnt++;
            step();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        d_s = NOP; e_s = NOP; m_s = NOP; w_wa = 5'd0;
        apply();
        #3;
        check_eq("rst_pc_en", 32'(PC_en), 1);
        check_eq("rst_ifid_en", 32'(IFID_en), 1);
        check_eq("rst_idex_clr", 32'(IDEX_clr), 0);
        check_eq("rst_fwd_d", 32'({FwdRS_D, FwdRT_D}), 0);
        check_eq("rst_fwd_em", 32'({FwdRS_E, FwdRT_E, FwdRT_M}), 0);
        check_eq("rst_md_start", 32'(md_start), 0);
        check_eq("rst_md_busy", 32'(md_busy), 0);
        check_eq("rst_stall_cnt", stall_cnt, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;

        // lw $1,0($0) ; addu $2,$1,$1
        prog.push_back(mk(i_type(6'h23, 5'd0, 5'd1, 16'd0), 5'd0, 5'd1, 5'd1));
        prog.push_back(mk(r_type(5'd1, 5'd1, 5'd2, 6'h21), 5'd1, 5'd1, 5'd2));
        step();
        step();
        count_stalls(20, n);
        check_eq("ld_cal_stalls", n, 1);
        step();
        check_eq("ld_cal_fwdrs_e", 32'(FwdRS_E), 1);
        check_eq("ld_cal_fwdrt_e", 32'(FwdRT_E), 1);
        check_eq("ld_cal_stall_cnt", stall_cnt, 1);

        // lw $1 ; beq $1,$0
        clear_pipe();
        prog.push_back(mk(i_type(6'h23, 5'd0, 5'd1, 16'd0), 5'd0, 5'd1, 5'd1));
        prog.push_back(mk(i_type(6'h04, 5'd1, 5'd0, 16'd3), 5'd1, 5'd0, 5'd0));
        step();
        step();
        count_stalls(20, n);
        check_eq("ld_br_stalls", n, 2);
        check_eq("ld_br_fwdrs_d", 32'(FwdRS_D), 1);
        check_eq("ld_br_fwdrt_d", 32'(FwdRT_D), 0);
        check_eq("ld_br_stall_cnt", stall_cnt, 3);

        // ori $3,$0,5 ; beq $3,$3
        clear_pipe();
        prog.push_back(mk(i_type(6'h0d, 5'd0, 5'd3, 16'd5), 5'd0, 5'd3, 5'd3));
        prog.push_back(mk(i_type(6'h04, 5'd3, 5'd3, 16'd0), 5'd3, 5'd3, 5'd0));
        step();
        step();
        count_stalls(20, n);
        check_eq("ori_br_stalls", n, 1);
        check_eq("ori_br_fwdrs_d", 32'(FwdRS_D), 2);
        check_eq("ori_br_fwdrt_d", 32'(FwdRT_D), 2);
        check_eq("ori_br_stall_cnt", stall_cnt, 4);

        // jal ; jr $31 in the delay slot
        clear_pipe();
        prog.push_back(mk({6'h03, 26'd64}, 5'd0, 5'd0, 5'd31));
        prog.push_back(mk(r_type(5'd31, 5'd0, 5'd0, 6'h08), 5'd31, 5'd0, 5'd0));
        step();
        step();
        check_eq("jal_jr_clr", 32'(IDEX_clr), 0);
        check_eq("jal_jr_fwdrs_d", 32'(FwdRS_D), 4);
        check_eq("jal_jr_fwdrt_d", 32'(FwdRT_D), 0);
        step();
        check_eq("jal_jr_fwdrs_e", 32'(FwdRS_E), 3);
        check_eq("jal_jr_stall_cnt", stall_cnt, 4);

        // mult $1,$2 ; mflo $4
        clear_pipe();
        prog.push_back(mk(r_type(5'd1, 5'd2, 5'd0, 6'h18), 5'd1, 5'd2, 5'd0));
        prog.push_back(mk(r_type(5'd0, 5'd0, 5'd4, 6'h12), 5'd0, 5'd0, 5'd4));
        step();
        step();
        check_eq("mult_md_start", 32'(md_start), 1);
        check_eq("mult_busy_pre", 32'(md_busy), 0);
        count_stalls(40, n);
        check_eq("mult_mf_stalls", n, 6);
        check_eq("mult_busy_post", 32'(md_busy), 0);
        check_eq("mult_stall_cnt", stall_cnt, 10);

        // div $1,$2 ; mflo $4
        clear_pipe();
        prog.push_back(mk(r_type(5'd1, 5'd2, 5'd0, 6'h1a), 5'd1, 5'd2, 5'd0));
        prog.push_back(mk(r_type(5'd0, 5'd0, 5'd4, 6'h12), 5'd0, 5'd0, 5'd4));
        step();
        step();
        count_stalls(40, n);
        check_eq("div_mf_stalls", n, 11);
        check_eq("div_stall_cnt", stall_cnt, 21);

        // div in E, reset pulsed three cycles later with mflo waiting in D
        clear_pipe();
        prog.push_back(mk(r_type(5'd1, 5'd2, 5'd0, 6'h1a), 5'd1, 5'd2, 5'd0));
        prog.push_back(mk(r_type(5'd0, 5'd0, 5'd4, 6'h12), 5'd0, 5'd0, 5'd4));
        step();
        step();
        step();
        step();
        step();
        check_eq("div_busy_mid", 32'(md_busy), 1);
        reset = 1'b0;
        #1;
        check_eq("rst_mid_busy", 32'(md_busy), 0);
        check_eq("rst_mid_stall_cnt", stall_cnt, 0);
        check_eq("rst_mid_clr", 32'(IDEX_clr), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        check_eq("post_rst_clr", 32'(IDEX_clr), 0);
        check_eq("post_rst_pc_en", 32'(PC_en), 1);
        step();
        check_eq("post_rst_stall_cnt", stall_cnt, 0);
        check_eq("post_rst_busy", 32'(md_busy), 0);

        // Forwarding priority and register-zero boundaries
        clear_pipe();
        e_s  = mk(r_type(5'd7, 5'd0, 5'd9, 6'h21), 5'd7, 5'd0, 5'd9);
        m_s  = mk(r_type(5'd3, 5'd4, 5'd7, 6'h21), 5'd3, 5'd4, 5'd7);
        w_wa = 5'd7;
        apply();
        #2;
        check_eq("fwd_e_exmem_first", 32'(FwdRS_E), 2);
        check_eq("fwd_e_zero_reg", 32'(FwdRT_E), 0);
        m_s = mk(i_type(6'h23, 5'd0, 5'd7, 16'd0), 5'd0, 5'd7, 5'd7);
        apply();
        #2;
        check_eq("fwd_e_ld_in_m", 32'(FwdRS_E), 1);
        m_s  = mk(i_type(6'h2b, 5'd0, 5'd5, 16'd0), 5'd0, 5'd5, 5'd0);
        w_wa = 5'd5;
        apply();
        #2;
        check_eq("fwd_m_hit", 32'(FwdRT_M), 1);
        w_wa = 5'd6;
        apply();
        #2;
        check_eq("fwd_m_miss", 32'(FwdRT_M), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
